// File: rtl/bucket_rmw_ctrl_if.sv
// Op request, response and RAM port-B signal bundle for bucket_rmw_ctrl.
// The slave modport is the controller's view; master is the environment (hash stage, consumer, RAM).
interface bucket_rmw_ctrl_if #(
  parameter int unsigned AW = 10,
  parameter int unsigned DW = 4
) ();

  logic          req_valid;
  logic          req_ready;
  logic [1:0]    req_op;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_data;

  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_old;
  logic [DW-1:0] rsp_new;
  logic          rsp_sat;
  logic          rsp_err;

  logic          ram_en;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;
  logic          ram_dout_valid;

  modport slave (
    input  req_valid, req_op, req_addr, req_data,
    output req_ready,
    output rsp_valid, rsp_old, rsp_new, rsp_sat, rsp_err,
    input  rsp_ready,
    output ram_en, ram_we, ram_addr, ram_din,
    input  ram_dout, ram_dout_valid
  );

  modport master (
    output req_valid, req_op, req_addr, req_data,
    input  req_ready,
    input  rsp_valid, rsp_old, rsp_new, rsp_sat, rsp_err,
    output rsp_ready,
    input  ram_en, ram_we, ram_addr, ram_din,
    output ram_dout, ram_dout_valid
  );

endinterface

// File: rtl/bucket_rmw_ctrl.sv
// Read-modify-write controller for port B of the cell RAM: read, saturating add, overwrite, clear.
// One op in flight; response is returned on a valid/ready channel with old/new value and flags.
module bucket_rmw_ctrl #(
  parameter int unsigned DEPTH   = 535,
  parameter int unsigned AW      = 10,
  parameter int unsigned DW      = 4,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  bucket_rmw_ctrl_if.slave     rmw,
  output logic [15:0]          sat_cnt_o
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam int unsigned CW = 16;

  localparam logic [1:0] OP_RD  = 2'b00;
  localparam logic [1:0] OP_ADD = 2'b01;
  localparam logic [1:0] OP_WR  = 2'b10;
  localparam logic [1:0] OP_CLR = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RD_ISSUE = 3'd1,
    S_RD_WAIT  = 3'd2,
    S_WR_ISSUE = 3'd3,
    S_WR_WAIT  = 3'd4,
    S_RESP     = 3'd5
  } state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [1:0]    op_q, op_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;
  logic [DW-1:0] old_q, old_d;
  logic [DW-1:0] new_q, new_d;
  logic          sat_q, sat_d;
  logic          err_q, err_d;
  logic [CW-1:0] sat_cnt_q, sat_cnt_d;

  logic          req_ready_q, req_ready_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [DW-1:0] rsp_old_q, rsp_old_d;
  logic [DW-1:0] rsp_new_q, rsp_new_d;
  logic          rsp_sat_q, rsp_sat_d;
  logic          rsp_err_q, rsp_err_d;
  logic          ram_en_q, ram_en_d;
  logic          ram_we_q, ram_we_d;
  logic [AW-1:0] ram_addr_q, ram_addr_d;
  logic [DW-1:0] ram_din_q, ram_din_d;

  logic          accept_c;
  logic          in_range_c;
  logic          timeout_c;
  logic [TW-1:0] timer_inc_c;
  logic [DW:0]   sum_c;

  assign accept_c    = rmw.req_valid && req_ready_q;
  assign in_range_c  = 32'(rmw.req_addr) < DEPTH;
  assign timeout_c   = (timer_q == TW'(TIMEOUT));
  assign timer_inc_c = (&timer_q) ? timer_q : timer_q + TW'(1);
  // Extra top bit of the sum flags overflow past the cell ceiling.
  assign sum_c       = {1'b0, rmw.ram_dout} + {1'b0, data_q};

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      op_q        <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      old_q       <= '0;
      new_q       <= '0;
      sat_q       <= 1'b0;
      err_q       <= 1'b0;
      sat_cnt_q   <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_old_q   <= '0;
      rsp_new_q   <= '0;
      rsp_sat_q   <= 1'b0;
      rsp_err_q   <= 1'b0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_din_q   <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      old_q       <= old_d;
      new_q       <= new_d;
      sat_q       <= sat_d;
      err_q       <= err_d;
      sat_cnt_q   <= sat_cnt_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_old_q   <= rsp_old_d;
      rsp_new_q   <= rsp_new_d;
      rsp_sat_q   <= rsp_sat_d;
      rsp_err_q   <= rsp_err_d;
      ram_en_q    <= ram_en_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_din_q   <= ram_din_d;
    end
  end

  // Next state, wait timer and op datapath.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    op_d      = op_q;
    addr_d    = addr_q;
    data_d    = data_q;
    old_d     = old_q;
    new_d     = new_q;
    sat_d     = sat_q;
    err_d     = err_q;
    sat_cnt_d = sat_cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          op_d   = rmw.req_op;
          addr_d = rmw.req_addr;
          data_d = rmw.req_data;
          old_d  = '0;
          new_d  = '0;
          sat_d  = 1'b0;
          err_d  = 1'b0;
          if (!in_range_c) begin
            err_d   = 1'b1;
            state_d = S_RESP;
          end else begin
            unique case (rmw.req_op)
              OP_RD, OP_ADD: state_d = S_RD_ISSUE;
              OP_WR: begin
                new_d   = rmw.req_data;
                state_d = S_WR_ISSUE;
              end
              OP_CLR: state_d = S_WR_ISSUE;
              default: state_d = S_IDLE;
            endcase
          end
        end
      end

      S_RD_ISSUE: begin
        timer_d = '0;
        state_d = S_RD_WAIT;
      end

      S_RD_WAIT: begin
        if (rmw.ram_dout_valid) begin
          old_d = rmw.ram_dout;
          if (op_q == OP_RD) begin
            new_d   = rmw.ram_dout;
            state_d = S_RESP;
          end else begin
            if (sum_c[DW]) begin
              new_d = '1;
              sat_d = 1'b1;
              if (sat_cnt_q != '1) begin
                sat_cnt_d = sat_cnt_q + CW'(1);
              end
            end else begin
              new_d = sum_c[DW-1:0];
            end
            state_d = S_WR_ISSUE;
          end
        end else if (timeout_c) begin
          old_d   = '0;
          new_d   = '0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          timer_d = timer_inc_c;
        end
      end

      S_WR_ISSUE: begin
        timer_d = '0;
        state_d = S_WR_WAIT;
      end

      S_WR_WAIT: begin
        if (rmw.ram_dout_valid) begin
          state_d = S_RESP;
        end else if (timeout_c) begin
          old_d   = '0;
          new_d   = '0;
          sat_d   = 1'b0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          timer_d = timer_inc_c;
        end
      end

      S_RESP: begin
        if (rmw.rsp_ready) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Output register next values, derived from the state being entered.
  always_comb begin
    req_ready_d = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_old_d   = '0;
    rsp_new_d   = '0;
    rsp_sat_d   = 1'b0;
    rsp_err_d   = 1'b0;
    ram_en_d    = 1'b0;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_din_d   = ram_din_q;

    req_ready_d = (state_d == S_IDLE);
    rsp_valid_d = (state_d == S_RESP);
    if (rsp_valid_d) begin
      rsp_old_d = old_d;
      rsp_new_d = new_d;
      rsp_sat_d = sat_d;
      rsp_err_d = err_d;
    end

    ram_en_d = (state_d == S_RD_ISSUE) || (state_d == S_WR_ISSUE);
    ram_we_d = (state_d == S_WR_ISSUE);
    // Address and write data only change on issue, so they stay put through the wait.
    if (ram_en_d) begin
      ram_addr_d = addr_d;
    end
    if (ram_we_d) begin
      ram_din_d = new_d;
    end
  end

  assign rmw.req_ready = req_ready_q;
  assign rmw.rsp_valid = rsp_valid_q;
  assign rmw.rsp_old   = rsp_old_q;
  assign rmw.rsp_new   = rsp_new_q;
  assign rmw.rsp_sat   = rsp_sat_q;
  assign rmw.rsp_err   = rsp_err_q;
  assign rmw.ram_en    = ram_en_q;
  assign rmw.ram_we    = ram_we_q;
  assign rmw.ram_addr  = ram_addr_q;
  assign rmw.ram_din   = ram_din_q;
  assign sat_cnt_o     = sat_cnt_q;

endmodule
